vec_tx_streamer: RTL

VEC_TX_STREAMER -- requirements
Module: vec_tx_streamer

---
 rtl/vec_tx_streamer_pkg.sv | 37 +++
 rtl/vec_tx_streamer_if.sv | 15 +
 rtl/vec_tx_streamer_uart_tx_handshake.sv | 56 +++++
 rtl/vec_tx_streamer.sv | 95 +++++++++
 4 files changed

// File: rtl/vec_tx_streamer_pkg.sv
// Shared definitions for the vector/scalar UART streamer: sizing defaults,
// FSM state encoding, processor opcodes and scalar byte selection.
package vec_tx_streamer_pkg;

  localparam int DEF_WIDTH    = 8;
  localparam int DEF_LENGTH   = 1024;
  localparam int CNT_W        = 11;   // one bit wider than IDX_W so LENGTH itself is reachable
  localparam int IDX_W        = 10;
  localparam int SCALAR_W     = 24;
  localparam int SCALAR_BYTES = 3;
  localparam int ACK_TIMEOUT  = 4;    // cycles to wait for tx_busy before assuming the byte went

  typedef enum logic [2:0] {
    IDLE, LOAD, SEND, WAIT_ACK, WAIT_FREE, DONE
  } state_t;

  // Processor opcodes (ASCII 'a'..'h')
  localparam logic [7:0] OP_WRITE_VEC_A = 8'd97;
  localparam logic [7:0] OP_WRITE_VEC_B = 8'd98;
  localparam logic [7:0] OP_READ_VEC_A  = 8'd99;
  localparam logic [7:0] OP_READ_VEC_B  = 8'd100;
  localparam logic [7:0] OP_SUM_VEC     = 8'd101;
  localparam logic [7:0] OP_DOT_PROD    = 8'd102;
  localparam logic [7:0] OP_MAN_DIST    = 8'd103;
  localparam logic [7:0] OP_EUC_DIST    = 8'd104;

  // Scalar results go out MSB first: byte 0 is bits [23:16].
  function automatic logic [7:0] scalar_byte(input logic [SCALAR_W-1:0] s,
                                             input logic [1:0] k);
    case (k)
      2'd0:    return s[23:16];
      2'd1:    return s[15:8];
      default: return s[7:0];
    endcase
  endfunction

endpackage

// File: rtl/vec_tx_streamer_if.sv
// Streamer-side bus: element fetch from the SIPO bank and byte path to the UART.
interface vec_tx_streamer_if
  import vec_tx_streamer_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) ();
  logic [WIDTH-1:0] tx_data;
  logic             tx_start;
  logic             tx_busy;
  logic [IDX_W-1:0] elem_idx;
  logic [WIDTH-1:0] elem_data;

  modport master (output tx_data, tx_start, elem_idx, input tx_busy, elem_data);
  modport slave  (input tx_data, tx_start, elem_idx, output tx_busy, elem_data);
endinterface

// File: rtl/vec_tx_streamer_uart_tx_handshake.sv
// Per-byte UART handshake: takes one byte via ready/valid, pulses tx_start,
// waits for the transmitter to go busy (with timeout) and then free again.
module uart_tx_handshake
  import vec_tx_streamer_pkg::*;
(
  input  logic clk,
  input  logic reset_n,
  input  logic byte_valid,
  output logic byte_ready,
  output logic byte_done,
  output logic tx_start,
  input  logic tx_busy
);
  localparam int ACK_W = $clog2(ACK_TIMEOUT);

  state_t           state, state_nxt;
  logic [ACK_W-1:0] ack_cnt;

  // State register and ack-timeout counter (counts only while in WAIT_ACK)
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      ack_cnt <= '0;
    end else begin
      state   <= state_nxt;
      ack_cnt <= (state == WAIT_ACK) ? ack_cnt + 1'b1 : '0;
    end
  end

  // Next-state and handshake outputs
  always_comb begin
    state_nxt  = state;
    byte_ready = 1'b0;
    byte_done  = 1'b0;
    tx_start   = 1'b0;
    case (state)
      IDLE: begin
        byte_ready = 1'b1;
        if (byte_valid) state_nxt = SEND;
      end
      SEND: begin
        tx_start  = 1'b1;
        state_nxt = WAIT_ACK;
      end
      WAIT_ACK:
        if (tx_busy || ack_cnt == ACK_W'(ACK_TIMEOUT - 1)) state_nxt = WAIT_FREE;
      WAIT_FREE:
        if (!tx_busy) begin
          byte_done = 1'b1;
          state_nxt = IDLE;
        end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: rtl/vec_tx_streamer.sv
// Streams either a full vector (LENGTH elements) or a 24-bit scalar result
// to the UART, one byte at a time. Owns byte counting and byte selection;
// the per-byte UART handshake lives in uart_tx_handshake.
module vec_tx_streamer
  import vec_tx_streamer_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int LENGTH = DEF_LENGTH
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start,
  input  logic                mode,
  input  logic [SCALAR_W-1:0] scalar_in,
  output logic                busy,
  output logic                done,
  vec_tx_streamer_if.master   bus
);
  // Top FSM uses IDLE/LOAD/WAIT_FREE/DONE; WAIT_FREE here means "byte handed
  // to the handshake, waiting for it to complete".
  state_t              state, state_nxt;
  logic                mode_q;
  logic [SCALAR_W-1:0] scalar_q;
  logic [CNT_W-1:0]    cnt;
  logic [WIDTH-1:0]    tx_data_q;
  logic [7:0]          sbyte;
  logic                last_byte;
  logic                byte_valid, byte_ready, byte_done;

  assign sbyte     = scalar_byte(scalar_q, cnt[1:0]);
  assign last_byte = mode_q ? (cnt == CNT_W'(SCALAR_BYTES - 1))
                            : (cnt == CNT_W'(LENGTH - 1));

  assign busy         = (state != IDLE);
  assign done         = (state == DONE);
  assign bus.tx_data  = tx_data_q;
  assign bus.elem_idx = mode_q ? '0 : cnt[IDX_W-1:0];

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Request capture, byte counter and held transmit byte
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mode_q    <= 1'b0;
      scalar_q  <= '0;
      cnt       <= '0;
      tx_data_q <= '0;
    end else begin
      case (state)
        IDLE:
          if (start) begin
            mode_q   <= mode;
            scalar_q <= scalar_in;
            cnt      <= '0;
          end
        LOAD:
          tx_data_q <= mode_q ? WIDTH'(sbyte) : bus.elem_data;
        WAIT_FREE:
          if (byte_done && !last_byte) cnt <= cnt + 1'b1;
        default: ;
      endcase
    end
  end

  // Next-state: one LOAD per byte, then hand off and wait for completion
  always_comb begin
    state_nxt  = state;
    byte_valid = 1'b0;
    case (state)
      IDLE:      if (start) state_nxt = LOAD;
      LOAD: begin
        byte_valid = 1'b1;
        if (byte_ready) state_nxt = WAIT_FREE;
      end
      WAIT_FREE: if (byte_done) state_nxt = last_byte ? DONE : LOAD;
      DONE:      state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  uart_tx_handshake u_hs (
    .clk        (clk),
    .reset_n    (reset_n),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .byte_done  (byte_done),
    .tx_start   (bus.tx_start),
    .tx_busy    (bus.tx_busy)
  );

endmodule
